elevator_car_controller: RTL and testbench
==========================================

# elevator_car_controller

Sequential controller for a single elevator car serving floors 0–6. It latches floor calls into a 7-bit request queue, selects travel direction, times floor-to-floor travel and door dwell, and clears serviced requests. It sits between the call-button inputs and the car motor/door drivers, and owns the queue and direction state the rest of the elevator logic reads.

## Interface
- TRAVEL_CYCLES, 8, clock cycles spent in MOVE per floor traversed (≥2)
- DOOR_CYCLES, 16, clock cycles the door stays open per stop (≥2)
- Counter width: $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES))

- clk  in  1  single system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- call_req  in  7  floor call mask; bit f high for one or more cycles requests floor f
- door_hold  in  1  while high in DOOR_OPEN, reloads the door counter
- queue_status  out  7  registered pending-request mask
- current_floor  out  3  registered floor index, 0–6
- up_ndown  out  1  current/last travel direction: 1 = up, 0 = down
- moving  out  1  high in MOVE
- door_open  out  1  high in DOOR_OPEN
- arrived  out  1  one-cycle pulse on each floor change

## Operation
- Reset values:
  - queue_status = 0, current_floor = 0, up_ndown = 1
  - moving = 0, door_open = 0, arrived = 0
  - state = IDLE, counters = 0
- Queue update each cycle: queue_next = (queue | call_req) & ~clear_mask.
  - clear_mask is the one-hot bit of the floor being serviced.
  - In DOOR_OPEN, and on the edge entering DOOR_OPEN, a call for current_floor is absorbed and never sets its bit.
- Direction rule, evaluated on queue_status:
  - above = OR of bits with index > current_floor; below = OR of bits with index < current_floor.
  - above only → up (1); below only → down (0); both or neither → keep up_ndown.
  - The rule never drives the car past floor 0 or floor 6.
- IDLE:
  - If queue bit [current_floor] is set → DOOR_OPEN; clear that bit.
  - Else if queue ≠ 0 → apply the direction rule; go to MOVE; load travel counter = TRAVEL_CYCLES-1.
  - Else stay in IDLE.
- MOVE:
  - Decrement the travel counter each cycle.
  - At counter 0: current_floor ± 1 per up_ndown, and pulse arrived. Then:
    - If the new floor's bit is set (including requests that arrived during travel) → DOOR_OPEN; clear that bit.
    - Else if queue ≠ 0 → apply the direction rule; stay in MOVE; reload the counter.
    - Else → IDLE.
- DOOR_OPEN:
  - Load door counter = DOOR_CYCLES-1 on entry; decrement each cycle.
  - door_hold high reloads DOOR_CYCLES-1.
  - At counter 0 with door_hold low → IDLE. IDLE then re-decides on the next cycle; there is no direct DOOR_OPEN→MOVE transition.

## Timing
- call_req is sampled on the rising edge; the bit is visible on queue_status the following cycle.
- IDLE→MOVE: one cycle after the request is visible in queue_status.
- Each floor costs exactly TRAVEL_CYCLES cycles with moving = 1.
- arrived is asserted in the first cycle showing the new current_floor.
- Each stop costs DOOR_CYCLES cycles with door_open = 1, plus any door_hold extension. A hold released at count c still completes the reloaded count.
- moving and door_open are never high together. Both are registered, with no combinational path from inputs to outputs.
- Simultaneous events:
  - A call for the floor being arrived at on the arrival edge is serviced by that stop.
  - A call for the same floor during door dwell is absorbed.
  - A reversing call during MOVE does not abort the current floor transition.
- Reset mid-MOVE or mid-DOOR_OPEN returns everything to the reset values immediately (asynchronous). Pending requests are lost.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n low mid-run, then release it with call_req = 0.
  - Response: all outputs at their reset values; IDLE held for 20 cycles, with moving = 0 and door_open = 0.
- Single trip with defaults:
  - Stimulus: at floor 0, pulse call_req = 7'b0001000.
  - Response: moving for 24 cycles; three arrived pulses with floors 1, 2, 3; door_open for 16 cycles; queue_status = 0 afterwards; return to IDLE.
- Call at current floor:
  - Stimulus: in IDLE at floor 0, call_req = 7'b0000001.
  - Response: door opens with no motion; bit 0 never set while the door is open.
- Direction hold:
  - Stimulus: car moving up from floor 2 toward floor 5; floor 0 is called mid-travel.
  - Response: car serves floor 5 first, then reverses (up_ndown = 0) and serves floor 0.
- Pickup en route:
  - Stimulus: car moving 0→6; floor 4 called while between floors 2 and 3.
  - Response: stops at 4 with 16-cycle dwell, then continues to 6.
- door_hold extension:
  - Stimulus: assert door_hold for 10 cycles starting 5 cycles into the dwell.
  - Response: door_open lasts 5 + 10 + 16 = 31 cycles.
- Reset during MOVE:
  - Stimulus: assert reset while the car is moving.
  - Response: moving = 0, current_floor = 0, queue_status = 0 asynchronously.

Source files
------------

// File: rtl/elevator_car_controller.sv
// Single-car elevator controller for floors 0-6: latches floor calls, picks the
// travel direction, times floor-to-floor travel and door dwell, and clears
// serviced requests.
module elevator_car_controller #(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] call_req,
    input  logic       door_hold,
    output logic [6:0] queue_status,
    output logic [2:0] current_floor,
    output logic       up_ndown,
    output logic       moving,
    output logic       door_open,
    output logic       arrived
);

    localparam int unsigned MaxCycles = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES
                                                                      : DOOR_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles);

    localparam logic [CntW-1:0] TravelLoad = CntW'(TRAVEL_CYCLES - 1);
    localparam logic [CntW-1:0] DoorLoad   = CntW'(DOOR_CYCLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMove = 2'd1;
    localparam logic [1:0] StDoor = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [6:0]      queue_q, queue_d;
    logic [2:0]      floor_q, floor_d;
    logic            dir_q, dir_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            arrived_q, arrived_d;
    logic            moving_q, door_q;

    logic [6:0]      queue_pend;
    logic [6:0]      clear_mask;
    logic [2:0]      floor_step;

    // Keep direction unless pending calls lie strictly on one side of floor f.
    function automatic logic pick_dir(input logic [6:0] q, input logic [2:0] f,
                                      input logic dir);
        logic       above;
        logic       below;
        logic [2:0] idx;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < 7; i++) begin
            idx = 3'(i);
            if (idx > f) above = above | q[i];
            if (idx < f) below = below | q[i];
        end
        if (above && !below) return 1'b1;
        if (below && !above) return 1'b0;
        return dir;
    endfunction

    assign floor_step = dir_q ? (floor_q + 3'd1) : (floor_q - 3'd1);

    // Next-state, queue maintenance and counter control.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        arrived_d  = 1'b0;
        clear_mask = 7'd0;
        // Calls landing on the arrival edge count toward that stop.
        queue_pend = queue_q | call_req;

        case (state_q)
            StIdle: begin
                if (queue_q[floor_q]) begin
                    state_d    = StDoor;
                    cnt_d      = DoorLoad;
                    clear_mask = 7'd1 << floor_q;
                end else if (|queue_q) begin
                    dir_d   = pick_dir(queue_q, floor_q, dir_q);
                    state_d = StMove;
                    cnt_d   = TravelLoad;
                end
            end
            StMove: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    floor_d   = floor_step;
                    arrived_d = 1'b1;
                    if (queue_pend[floor_step]) begin
                        state_d    = StDoor;
                        cnt_d      = DoorLoad;
                        clear_mask = 7'd1 << floor_step;
                    end else if (|queue_q) begin
                        dir_d = pick_dir(queue_q, floor_step, dir_q);
                        cnt_d = TravelLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDoor: begin
                // Same-floor calls during dwell are absorbed.
                clear_mask = 7'd1 << floor_q;
                if (door_hold) begin
                    cnt_d = DoorLoad;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        queue_d = queue_pend & ~clear_mask;
    end

    // State and registered outputs; async reset drops all pending requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            queue_q   <= 7'd0;
            floor_q   <= 3'd0;
            dir_q     <= 1'b1;
            cnt_q     <= '0;
            arrived_q <= 1'b0;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            queue_q   <= queue_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            arrived_q <= arrived_d;
            moving_q  <= (state_d == StMove);
            door_q    <= (state_d == StDoor);
        end
    end

    assign queue_status  = queue_q;
    assign current_floor = floor_q;
    assign up_ndown      = dir_q;
    assign moving        = moving_q;
    assign door_open     = door_q;
    assign arrived       = arrived_q;

endmodule

// File: tb/tb_elevator_car_controller.sv
// Self-checking bench for elevator_car_controller: directed scenarios with
// literal expectations plus a randomized run against a behavioural car model.
module tb_elevator_car_controller;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] call_req = 7'd0;
    logic       door_hold = 1'b0;
    logic [6:0] queue_status;
    logic [2:0] current_floor;
    logic       up_ndown;
    logic       moving;
    logic       door_open;
    logic       arrived;

    int n_checks = 0;
    int n_fail   = 0;

    elevator_car_controller #(
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DOOR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .call_req     (call_req),
        .door_hold    (door_hold),
        .queue_status (queue_status),
        .current_floor(current_floor),
        .up_ndown     (up_ndown),
        .moving       (moving),
        .door_open    (door_open),
        .arrived      (arrived)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The car is either parked, travelling or dwelling; m_left counts the cycles
    // still to spend in the current travel leg or dwell, including the next one.
    bit [6:0] m_queue  = 7'd0;
    int       m_floor  = 0;
    bit       m_dir    = 1'b1;
    bit       m_moving = 1'b0;
    bit       m_door   = 1'b0;
    bit       m_arr    = 1'b0;
    int       m_left   = 0;

    function automatic bit model_dir(input int q, input int f, input bit d);
        bit above;
        bit below;
        above = (q >> (f + 1)) != 0;
        below = (q % (1 << f)) != 0;
        if (above != below) return above;
        return d;
    endfunction

    task automatic model_reset();
        m_queue  = 7'd0;
        m_floor  = 0;
        m_dir    = 1'b1;
        m_moving = 1'b0;
        m_door   = 1'b0;
        m_arr    = 1'b0;
        m_left   = 0;
    endtask

    task automatic model_step();
        bit [6:0] nq;
        int       f;
        nq    = m_queue | call_req;
        m_arr = 1'b0;
        if (!m_moving && !m_door) begin
            if (m_queue[m_floor]) begin
                m_door      = 1'b1;
                m_left      = DOOR;
                nq[m_floor] = 1'b0;
            end else if (m_queue != 0) begin
                m_dir    = model_dir(m_queue, m_floor, m_dir);
                m_moving = 1'b1;
                m_left   = TRAVEL;
            end
        end else if (m_moving) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                f       = m_dir ? m_floor + 1 : m_floor - 1;
                m_floor = f;
                m_arr   = 1'b1;
                if (nq[f]) begin
                    m_moving = 1'b0;
                    m_door   = 1'b1;
                    m_left   = DOOR;
                    nq[f]    = 1'b0;
                end else if (m_queue != 0) begin
                    m_dir  = model_dir(m_queue, f, m_dir);
                    m_left = TRAVEL;
                end else begin
                    m_moving = 1'b0;
                end
            end
        end else begin
            nq[m_floor] = 1'b0;
            if (door_hold) m_left = DOOR;
            else if (m_left > 1) m_left--;
            else m_door = 1'b0;
        end
        m_queue = nq;
    endtask

    // Model advances on the same edges as the DUT, including async reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Compare every cycle the car is out of reset, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("queue_status", queue_status, m_queue);
            check("current_floor", current_floor, m_floor);
            check("up_ndown", up_ndown, m_dir);
            check("moving", moving, m_moving);
            check("door_open", door_open, m_door);
            check("arrived", arrived, m_arr);
            check("moving_door_excl", moving & door_open, 0);
        end
    end

    // ---------------- scenario monitor ----------------
    int stop_floors[$];
    int stop_dirs[$];
    int dwells[$];
    int arr_floors[$];
    int move_cycles = 0;
    int dwell_run   = 0;
    int absorb_viol = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (moving) move_cycles++;
            if (arrived) arr_floors.push_back(int'(current_floor));
            if (door_open && queue_status[current_floor]) absorb_viol++;
            if (door_open) begin
                if (dwell_run == 0) begin
                    stop_floors.push_back(int'(current_floor));
                    stop_dirs.push_back(int'(up_ndown));
                end
                dwell_run++;
            end else if (dwell_run > 0) begin
                dwells.push_back(dwell_run);
                dwell_run = 0;
            end
        end
    end

    task automatic clear_mon();
        stop_floors.delete();
        stop_dirs.delete();
        dwells.delete();
        arr_floors.delete();
        move_cycles = 0;
        absorb_viol = 0;
    endtask

    task automatic call(input logic [6:0] mask);
        @(negedge clk);
        call_req = mask;
        @(negedge clk);
        call_req = 7'd0;
    endtask

    task automatic wait_idle(input string tag);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            if (!moving && !door_open && queue_status == 7'd0) quiet++;
            else quiet = 0;
        end
        check({"idle_timeout_", tag}, (quiet >= 3), 1);
    endtask

    task automatic wait_floor_moving(input int f, input string tag);
        int n;
        n = 0;
        while (!(moving && current_floor == 3'(f)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({"reach_timeout_", tag}, (n < 2000), 1);
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_queue", queue_status, 0);
        check("rst_floor", current_floor, 0);
        check("rst_dir", up_ndown, 1);
        check("rst_moving", moving, 0);
        check("rst_door", door_open, 0);
        check("rst_arrived", arrived, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_hold", {30'd0, moving, door_open}, 0);
        end

        // Call at current floor: door opens, car never moves, bit never set
        clear_mon();
        call(7'b0000001);
        wait_idle("here");
        check("here_moves", move_cycles, 0);
        check("here_absorb", absorb_viol, 0);
        check("here_stops", stop_floors.size(), 1);
        if (dwells.size() == 1) check("here_dwell", dwells[0], DOOR);

        // Single trip 0 -> 3
        clear_mon();
        call(7'b0001000);
        wait_idle("trip");
        check("trip_move_cycles", move_cycles, 3 * TRAVEL);
        check("trip_arrivals", arr_floors.size(), 3);
        if (arr_floors.size() == 3) begin
            check("trip_arr0", arr_floors[0], 1);
            check("trip_arr1", arr_floors[1], 2);
            check("trip_arr2", arr_floors[2], 3);
        end
        check("trip_dwells", dwells.size(), 1);
        if (dwells.size() == 1) check("trip_dwell", dwells[0], DOOR);
        check("trip_queue_after", queue_status, 0);

        // door_hold extension at floor 1
        clear_mon();
        call(7'b0000010);
        begin
            int n;
            n = 0;
            while (door_open !== 1'b1 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("hold_door_timeout", (n < 1000), 1);
        end
        repeat (5) @(negedge clk);
        door_hold = 1'b1;
        repeat (10) @(negedge clk);
        door_hold = 1'b0;
        wait_idle("hold");
        check("hold_dwells", dwells.size(), 1);
        if (dwells.size() == 1) check("hold_dwell", dwells[0], 5 + 10 + DOOR);

        // Direction hold: park at 2, head for 5, floor 0 called mid-travel
        call(7'b0000100);
        wait_idle("park2");
        check("park2_floor", current_floor, 2);
        clear_mon();
        call(7'b0100000);
        wait_floor_moving(3, "dirhold");
        call(7'b0000001);
        wait_idle("dirhold");
        check("dirhold_stops", stop_floors.size(), 2);
        if (stop_floors.size() == 2) begin
            check("dirhold_first", stop_floors[0], 5);
            check("dirhold_second", stop_floors[1], 0);
            check("dirhold_dir_at0", stop_dirs[1], 0);
        end

        // Pickup en route: 0 -> 6, floor 4 called between 2 and 3
        clear_mon();
        call(7'b1000000);
        wait_floor_moving(2, "pickup");
        repeat (3) @(negedge clk);
        call(7'b0010000);
        wait_idle("pickup");
        check("pickup_stops", stop_floors.size(), 2);
        if (stop_floors.size() == 2 && dwells.size() == 2) begin
            check("pickup_first", stop_floors[0], 4);
            check("pickup_second", stop_floors[1], 6);
            check("pickup_dwell4", dwells[0], DOOR);
        end

        // Reset during MOVE, asserted between clock edges
        call(7'b0000001);
        wait_floor_moving(6, "rstmove");
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_moving", moving, 0);
        check("async_floor", current_floor, 0);
        check("async_queue", queue_status, 0);
        check("async_door", door_open, 0);
        check("async_dir", up_ndown, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model, with one more mid-run reset
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            call_req  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            door_hold = ($urandom_range(0, 15) == 0);
            if (c == 1500) begin
                #3;
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        call_req  = 7'd0;
        door_hold = 1'b0;
        wait_idle("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
